adder_multicycle: RTL and testbench
===================================

ADDER_MULTICYCLE -- requirements
Module: adder_multicycle

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL provide parameter CHUNK, default 8, bits added per clock cycle; WIDTH SHALL be a nonzero multiple of CHUNK, N = WIDTH/CHUNK.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port start  input  1  request a new operation; accepted only when busy=0.
REQ-006 SHALL provide port in1  input  WIDTH  first operand, captured at accept.
REQ-007 SHALL provide port in2  input  WIDTH  second operand, captured at accept.
REQ-008 SHALL provide port cin  input  1  carry-in for add mode, captured at accept.
REQ-009 SHALL provide port sub  input  1  0 = add, 1 = subtract, captured at accept.
REQ-010 SHALL provide port busy  output  1  high while an accepted operation is in progress (RUN or DONE).
REQ-011 SHALL provide port done  output  1  one-cycle pulse marking a new valid result.
REQ-012 SHALL provide port sum  output  WIDTH  result.
REQ-013 SHALL provide port cout  output  1  carry out of bit WIDTH-1.
REQ-014 SHALL provide port ovf  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; IDLE -> RUN on start=1; RUN -> DONE after N RUN cycles; DONE -> IDLE unconditionally after one cycle.
REQ-016 On accept, SHALL capture in1, in2 (inverted if sub=1), and carry = sub ? 1 : cin; cin SHALL be ignored when sub=1.
REQ-017 In each RUN cycle k (k = 0..N-1), SHALL add operand bits [k*CHUNK +: CHUNK] plus the stored carry, write the CHUNK-bit result into an internal accumulator, and store the chunk carry-out for cycle k+1.
REQ-018 Arithmetic SHALL be modulo 2^WIDTH; result SHALL equal in1 + in2 + cin (add) or in1 + ~in2 + 1 (sub).
REQ-019 cout SHALL be the carry out of the final chunk; in sub mode cout=1 means no borrow (in1 >= in2 unsigned).
REQ-020 ovf SHALL be 1 iff in1[WIDTH-1] equals the effective in2[WIDTH-1] (after inversion) and sum[WIDTH-1] differs from it.
REQ-021 sum, cout, ovf SHALL update only on the RUN -> DONE transition and SHALL hold until the next RUN -> DONE transition; intermediate chunks SHALL NOT appear on outputs.
REQ-022 Latency: start accepted in cycle 0 -> busy=1 in cycles 1..N+1, done=1 in cycle N+1 only, results valid from cycle N+1.
REQ-023 start while busy=1 (including during DONE) SHALL be ignored and SHALL NOT be queued.
REQ-024 Next accept earliest in cycle N+2 (first IDLE cycle); operand changes while busy SHALL have no effect.
REQ-025 N=1 SHALL be supported: done in cycle 2.

Reset
REQ-026 rst=1 SHALL force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, and clear internal carry, accumulator, and chunk index.
REQ-027 rst SHALL take priority over start and over any in-progress operation; an aborted operation SHALL produce no done pulse.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-028 Reset: rst high 2 cycles -> busy=0, done=0, sum=0, cout=0, ovf=0.
REQ-029 Add carry chain: in1=0xFFFFFFFF, in2=0, cin=1, sub=0, start in cycle 0 -> done only in cycle 5, sum=0x00000000, cout=1, ovf=0.
REQ-030 Signed overflow: in1=0x7FFFFFFF, in2=1, cin=0 -> sum=0x80000000, cout=0, ovf=1; sub in1=0x80000000, in2=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
REQ-031 Subtract borrow: in1=5, in2=7, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0, ovf=0 (cin ignored).
REQ-032 Handshake: start held high for 10 cycles -> accepts in cycles 0 and 6 only, done in cycles 5 and 11; operands changed in cycle 2 do not affect the first result.
REQ-033 Abort and N=1: rst in cycle 3 of an operation -> no done, outputs 0, next start accepted normally; WIDTH=8, CHUNK=8, in1=0xFF, in2=0x01 -> done in cycle 2, sum=0x00, cout=1, ovf=0.

Source files
------------

// File: rtl/adder_multicycle.sv
// Multi-cycle ripple adder/subtractor: adds one CHUNK-bit slice per clock and
// publishes sum/cout/ovf only when the last slice completes.
module adder_multicycle #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK:0]   chunk_res;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    chunk_res = {1'b0, op1_q[idx_q*CHUNK +: CHUNK]} + {1'b0, op2_q[idx_q*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
    acc_next  = acc_q;
    acc_next[idx_q*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Subtraction is a + ~b + 1, so the +1 rides in as the initial carry.
          op1_d   = in1;
          op2_d   = sub ? ~in2 : in2;
          carry_d = sub | cin;
          acc_d   = '0;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d   = acc_next;
        carry_d = chunk_res[CHUNK];
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StDone;
          sum_d   = acc_next;
          cout_d  = chunk_res[CHUNK];
          ovf_d   = (op1_q[WIDTH-1] == op2_q[WIDTH-1]) &&
                    (acc_next[WIDTH-1] != op1_q[WIDTH-1]);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op1_q   <= '0;
      op2_q   <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_adder_multicycle.sv
// Directed bench for adder_multicycle: 32/8 instance driven through a result
// scoreboard, plus an 8/8 instance for the single-chunk case.
module tb_adder_multicycle;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, cin, sub;
  logic [31:0] in1, in2;
  logic        busy, done, cout, ovf;
  logic [31:0] sum;

  logic        rst8, start8, cin8, sub8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  adder_multicycle #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .in1  (in1),
    .in2  (in2),
    .cin  (cin),
    .sub  (sub),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  adder_multicycle #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk  (clk),
    .rst  (rst8),
    .start(start8),
    .in1  (a8),
    .in2  (b8),
    .cin  (cin8),
    .sub  (sub8),
    .busy (busy8),
    .done (done8),
    .sum  (sum8),
    .cout (cout8),
    .ovf  (ovf8)
  );

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Whole-word reference: one wide addition, no slicing.
  function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic c, logic s);
    exp_t        m;
    logic [31:0] e2;
    logic [32:0] r;
    e2     = s ? ~b : b;
    r      = {1'b0, a} + {1'b0, e2} + {32'd0, (s ? 1'b1 : c)};
    m.sum  = r[31:0];
    m.cout = r[32];
    m.ovf  = (a[31] == e2[31]) && (r[31] != a[31]);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_sum"}, sum, e.sum);
      chk({tag, "_cout"}, 32'(cout), 32'(e.cout));
      chk({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
    end
  endtask

  // Start in cycle 0; busy in 1..5, done only in 5, idle again in 6.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic s);
    in1   = a;
    in2   = b;
    cin   = c;
    sub   = s;
    start = 1'b1;
    sb.push_back(model(a, b, c, s));
    step();
    start = 1'b0;
    in1   = $urandom;
    in2   = $urandom;
    cin   = ~c;
    sub   = ~s;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done"}, 32'(done), 32'(cyc == 5));
      if (done === 1'b1) check_result(tag);
      step();
    end
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0; cin = 1'b0; sub = 1'b0;
    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst8_busy", 32'(busy8), 32'd0);
    chk("rst8_sum", 32'(sum8), 32'd0);
    rst = 1'b0;
    rst8 = 1'b0;
    step();

    run_op("carry", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    chk("carry_lit_sum", sum, 32'h0000_0000);
    chk("carry_lit_cout", 32'(cout), 32'd1);
    chk("carry_lit_ovf", 32'(ovf), 32'd0);

    run_op("sovf_add", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    chk("sovf_add_lit_sum", sum, 32'h8000_0000);
    chk("sovf_add_lit_ovf", 32'(ovf), 32'd1);

    run_op("sovf_sub", 32'h8000_0000, 32'h1, 1'b0, 1'b1);
    chk("sovf_sub_lit_sum", sum, 32'h7FFF_FFFF);
    chk("sovf_sub_lit_cout", 32'(cout), 32'd1);
    chk("sovf_sub_lit_ovf", 32'(ovf), 32'd1);

    run_op("borrow", 32'd5, 32'd7, 1'b1, 1'b1);
    chk("borrow_lit_sum", sum, 32'hFFFF_FFFE);
    chk("borrow_lit_cout", 32'(cout), 32'd0);
    chk("borrow_lit_ovf", 32'(ovf), 32'd0);

    for (int i = 0; i < 4; i++) begin
      run_op("rand", $urandom, $urandom, 1'($urandom_range(1)), 1'(i % 2));
    end

    // Handshake: start held for cycles 0..9, operands swapped in cycle 2.
    in1 = 32'h1234_00FF; in2 = 32'h0F0F_FF01; cin = 1'b1; sub = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      if (c == 0) begin
        start = 1'b1;
        sb.push_back(model(in1, in2, cin, sub));
      end
      if (c == 2) begin
        in1 = 32'h0000_0010; in2 = 32'h0000_0020; cin = 1'b0; sub = 1'b1;
      end
      if (c == 6) sb.push_back(model(in1, in2, cin, sub));
      if (c == 10) start = 1'b0;
      chk($sformatf("hs_busy_c%0d", c), 32'(busy),
          32'(((c >= 1) && (c <= 5)) || ((c >= 7) && (c <= 11))));
      chk($sformatf("hs_done_c%0d", c), 32'(done), 32'((c == 5) || (c == 11)));
      if (done === 1'b1) check_result($sformatf("hs_c%0d", c));
      step();
    end

    // Leave nonzero sum/cout/ovf on the outputs, then abort the next op.
    run_op("pre_abort", 32'h8000_0000, 32'h1, 1'b0, 1'b1);
    in1 = 32'hDEAD_BEEF; in2 = 32'h1111_1111; cin = 1'b0; sub = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum", sum, 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("abort_nodone_%0d", c), 32'(done), 32'd0);
      step();
    end
    run_op("post_abort", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);

    // Single-chunk instance: done in cycle 2.
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    chk("n1_c1_busy", 32'(busy8), 32'd1);
    chk("n1_c1_done", 32'(done8), 32'd0);
    step();
    chk("n1_c2_done", 32'(done8), 32'd1);
    chk("n1_sum", 32'(sum8), 32'h00);
    chk("n1_cout", 32'(cout8), 32'd1);
    chk("n1_ovf", 32'(ovf8), 32'd0);
    step();
    chk("n1_c3_busy", 32'(busy8), 32'd0);
    chk("n1_c3_done", 32'(done8), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
